// File: rtl/sobel_edge_binarize.sv
// Purpose     : 3x3 Sobel edge detector that emits one edge flag per greyscale pixel, with frame syncs delayed to match.
// Latency     : fixed 4 clk from pixel input to flag output; the pipeline advances every clk, independent of clken gaps.
// Backpressure: none; the stream cannot be stalled, so a pixel is consumed in any cycle with pre_frame_clken & pre_frame_href.
//
// Ports:
//   clk, rst                        pixel clock; synchronous active-high reset
//   pre_frame_vsync/href/clken      input frame sync, line valid, pixel strobe
//   pre_img_y[7:0]                  greyscale pixel
//   threshold[10:0]                 edge threshold (edge when magnitude > threshold), sampled every cycle
//   post_frame_vsync/href/clken     input syncs delayed by exactly 4 clk
//   post_img_bit                    edge flag, valid when post_frame_clken = 1
//   post_mag[10:0]                  |gx|+|gy| aligned with post_img_bit; only present when SOBEL_MAG_OUT_EN is defined
//
// Build option: define SOBEL_MAG_OUT_EN to expose the S4 magnitude on post_mag.
//
// Geometry: the window centre for the pixel accepted at (row, col) is (row-1, col-1). Results for
// source rows 0-1 and source cols 0-1 are forced to 0, which also hides stale line-buffer contents
// left over from the previous frame or from before a reset.

module sobel_edge_binarize #(
    parameter int IMG_WIDTH  = 640,  // active pixels per line
    parameter int IMG_HEIGHT = 480,  // active lines per frame
    parameter int CNT_W      = 11    // row/column counter width
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_clken,
    input  logic [7:0]  pre_img_y,
    input  logic [10:0] threshold,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_bit
`ifdef SOBEL_MAG_OUT_EN
    ,
    output logic [10:0] post_mag
`endif
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] BORDER_LO = CNT_W'(2);

    // ------------------------------------------------------------------
    // Input qualification and sync edge detection
    // ------------------------------------------------------------------
    logic accept;
    logic vsync_q;
    logic href_q;
    logic vsync_rise;
    logic href_fall;

    assign accept     = pre_frame_clken & pre_frame_href;
    assign vsync_rise = pre_frame_vsync & ~vsync_q;
    assign href_fall  = href_q & ~pre_frame_href;

    // ------------------------------------------------------------------
    // Row / column counters (position of the pixel currently presented)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        if (href_fall) begin
            col_d = '0;
        end else if (accept) begin
            // An over-length line wraps rather than running past the line buffers.
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
    end

    always_comb begin
        row_d = row_q;
        // Frame start wins over the line-end increment when both happen together.
        if (vsync_rise) begin
            row_d = '0;
        end else if (href_fall && (row_q != CNT_MAX)) begin
            row_d = row_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds the previous line, lb2 the one before it.
    // Read asynchronously at the current column, then overwritten in place,
    // so each column slot rolls down one line per accepted pixel.
    // ------------------------------------------------------------------
    logic [7:0]    lb1_mem [IMG_WIDTH];
    logic [7:0]    lb2_mem [IMG_WIDTH];
    logic [AW-1:0] lb_addr;
    logic [7:0]    lb1_rd;
    logic [7:0]    lb2_rd;

    assign lb_addr = col_q[AW-1:0];
    assign lb1_rd  = lb1_mem[lb_addr];
    assign lb2_rd  = lb2_mem[lb_addr];

    // Storage is deliberately not reset; border suppression hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb1_mem[lb_addr] <= pre_img_y;
            lb2_mem[lb_addr] <= lb1_rd;
        end
    end

    // ------------------------------------------------------------------
    // S1: 3x3 window. pRC: R = 1 top (row-2) .. 3 bottom (row), C = 1 oldest .. 3 newest column.
    // ------------------------------------------------------------------
    logic [7:0] p11_q, p12_q, p13_q;
    logic [7:0] p21_q, p22_q, p23_q;
    logic [7:0] p31_q, p32_q, p33_q;
    logic       s1_vld_q, s1_ok_q;
    logic       pos_ok;

    assign pos_ok = (row_q >= BORDER_LO) && (col_q >= BORDER_LO);

    // ------------------------------------------------------------------
    // S2: signed gradients
    // ------------------------------------------------------------------
    logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_d, gy_d;
    logic signed [10:0] gx_q, gy_q;
    logic               s2_vld_q, s2_ok_q;

    always_comb begin
        gx_pos = {3'b000, p13_q} + {2'b00, p23_q, 1'b0} + {3'b000, p33_q};
        gx_neg = {3'b000, p11_q} + {2'b00, p21_q, 1'b0} + {3'b000, p31_q};
        gy_pos = {3'b000, p31_q} + {2'b00, p32_q, 1'b0} + {3'b000, p33_q};
        gy_neg = {3'b000, p11_q} + {2'b00, p12_q, 1'b0} + {3'b000, p13_q};
        gx_d   = $signed(gx_pos - gx_neg);
        gy_d   = $signed(gy_pos - gy_neg);
    end

    // ------------------------------------------------------------------
    // S3: absolute values (|g| <= 1020 always fits 10 bits)
    // ------------------------------------------------------------------
    logic [9:0] absx_d, absy_d;
    logic [9:0] absx_q, absy_q;
    logic       s3_vld_q, s3_ok_q;

    always_comb begin
        absx_d = gx_q[10] ? 10'(-gx_q) : 10'(gx_q);
        absy_d = gy_q[10] ? 10'(-gy_q) : 10'(gy_q);
    end

    // ------------------------------------------------------------------
    // S4: magnitude and strict threshold compare, masked by validity and border
    // ------------------------------------------------------------------
    logic [10:0] mag_d;
    logic        keep_s3;
    logic        edge_d;
    logic        edge_q;

    assign mag_d   = {1'b0, absx_q} + {1'b0, absy_q};
    assign keep_s3 = s3_vld_q & s3_ok_q;
    assign edge_d  = keep_s3 & (mag_d > threshold);

    // ------------------------------------------------------------------
    // Sync delay lines: 4 stages to match S1..S4
    // ------------------------------------------------------------------
    logic [3:0] vsync_dly_q;
    logic [3:0] href_dly_q;
    logic [3:0] clken_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            p11_q       <= '0;
            p12_q       <= '0;
            p13_q       <= '0;
            p21_q       <= '0;
            p22_q       <= '0;
            p23_q       <= '0;
            p31_q       <= '0;
            p32_q       <= '0;
            p33_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_ok_q     <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            s2_vld_q    <= 1'b0;
            s2_ok_q     <= 1'b0;
            absx_q      <= '0;
            absy_q      <= '0;
            s3_vld_q    <= 1'b0;
            s3_ok_q     <= 1'b0;
            edge_q      <= 1'b0;
            vsync_dly_q <= '0;
            href_dly_q  <= '0;
            clken_dly_q <= '0;
        end else begin
            vsync_q <= pre_frame_vsync;
            href_q  <= pre_frame_href;
            col_q   <= col_d;
            row_q   <= row_d;

            // S1: the window only moves on an accepted pixel; stages behind it run every clk.
            if (accept) begin
                p11_q <= p12_q;
                p12_q <= p13_q;
                p13_q <= lb2_rd;
                p21_q <= p22_q;
                p22_q <= p23_q;
                p23_q <= lb1_rd;
                p31_q <= p32_q;
                p32_q <= p33_q;
                p33_q <= pre_img_y;
            end
            s1_vld_q <= accept;
            s1_ok_q  <= pos_ok;

            // S2
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            s2_vld_q <= s1_vld_q;
            s2_ok_q  <= s1_ok_q;

            // S3
            absx_q   <= absx_d;
            absy_q   <= absy_d;
            s3_vld_q <= s2_vld_q;
            s3_ok_q  <= s2_ok_q;

            // S4
            edge_q <= edge_d;

            vsync_dly_q <= {vsync_dly_q[2:0], pre_frame_vsync};
            href_dly_q  <= {href_dly_q[2:0],  pre_frame_href};
            clken_dly_q <= {clken_dly_q[2:0], pre_frame_clken};
        end
    end

`ifdef SOBEL_MAG_OUT_EN
    logic [10:0] mag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
        end else begin
            mag_q <= keep_s3 ? mag_d : 11'd0;
        end
    end

    assign post_mag = mag_q;
`endif

    assign post_frame_vsync = vsync_dly_q[3];
    assign post_frame_href  = href_dly_q[3];
    assign post_frame_clken = clken_dly_q[3];
    assign post_img_bit     = edge_q;

endmodule

// File: tb/tb_sobel_edge_binarize.sv
// Purpose     : directed self-checking bench for sobel_edge_binarize.
// Latency     : outputs compared one clk step at a time against the inputs applied 4 clk earlier.
// Backpressure: none; the bench drives a free-running stream.

module tb_sobel_edge_binarize;

    localparam int W = 640;

    logic        clk;
    logic        rst;
    logic        pre_frame_vsync;
    logic        pre_frame_href;
    logic        pre_frame_clken;
    logic [7:0]  pre_img_y;
    logic [10:0] threshold;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic        post_img_bit;
`ifdef SOBEL_MAG_OUT_EN
    logic [10:0] post_mag;
`endif

    int checks;
    int failures;

    // Expectation history: index 0 = inputs of the current step, index 3 = inputs 3 steps ago,
    // which is what the outputs show right after the current step's clock edge.
    logic [2:0] h_sync [4];
    logic       h_bit  [4];
    logic       h_chk  [4];
    int         h_mag  [4];

    sobel_edge_binarize #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(480),
        .CNT_W     (11)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pre_frame_vsync (pre_frame_vsync),
        .pre_frame_href  (pre_frame_href),
        .pre_frame_clken (pre_frame_clken),
        .pre_img_y       (pre_img_y),
        .threshold       (threshold),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .post_img_bit    (post_img_bit)
`ifdef SOBEL_MAG_OUT_EN
        ,
        .post_mag        (post_mag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step: drive inputs, advance one edge, compare outputs with the entry from 3 steps ago.
    // em: expected magnitude (-1 = not known for this pixel); eb: expected edge flag; chk: compare the flag.
    task automatic tick(input logic v, input logic h, input logic ce, input logic [7:0] y,
                        input logic r, input logic eb, input logic chk, input int em);
        pre_frame_vsync = v;
        pre_frame_href  = h;
        pre_frame_clken = ce;
        pre_img_y       = y;
        rst             = r;
        for (int i = 3; i > 0; i--) begin
            h_sync[i] = h_sync[i-1];
            h_bit[i]  = h_bit[i-1];
            h_chk[i]  = h_chk[i-1];
            h_mag[i]  = h_mag[i-1];
        end
        h_sync[0] = {v, h, ce};
        h_bit[0]  = eb;
        h_chk[0]  = chk;
        h_mag[0]  = em;
        if (r) begin
            // Reset flushes everything in flight; all outputs must read 0 afterwards.
            for (int i = 0; i < 4; i++) begin
                h_sync[i] = 3'b000;
                h_bit[i]  = 1'b0;
                h_chk[i]  = 1'b1;
                h_mag[i]  = 0;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        assert ({post_frame_vsync, post_frame_href, post_frame_clken} === h_sync[3]) else begin
            failures++;
            $error("FAIL sync_delay got=%b want=%b", {post_frame_vsync, post_frame_href, post_frame_clken}, h_sync[3]);
        end
        if (h_chk[3]) begin
            checks++;
            assert (post_img_bit === h_bit[3]) else begin
                failures++;
                $error("FAIL edge_bit got=%b want=%b", post_img_bit, h_bit[3]);
            end
        end
`ifdef SOBEL_MAG_OUT_EN
        if (h_mag[3] >= 0) begin
            checks++;
            assert (post_mag === 11'(h_mag[3])) else begin
                failures++;
                $error("FAIL post_mag got=%0d want=%0d", post_mag, h_mag[3]);
            end
        end
`endif
    endtask

    // Patterns: 0 flat 0x80, 1 vertical step at col 320, 2 random, 3 checkerboard, 4 single 0xFF at (10,10).
    // Expected magnitudes are derived by hand from the Sobel kernels:
    //   step      : 4*255 = 1020 where the window straddles the step (source cols 320, 321), else 0
    //   single dot: 510 for every source position whose 3x3 window holds the dot off-centre, 0 at centre
    //   flat/checkerboard: 0 everywhere
    task automatic send_frame(input int pat, input int rows, input int th, input bit gaps,
                              input int rst_r, input int rst_c);
        logic [7:0] y;
        int         em;
        bit         dead;
        threshold = 11'(th);
        dead      = 1'b0;
        repeat (4) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == rst_r && c == rst_c) begin
                    tick(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 0);
                    dead = 1'b1;
                end else begin
                    case (pat)
                        0: begin y = 8'h80; em = 0; end
                        1: begin
                            y  = (c >= 320) ? 8'hFF : 8'h00;
                            em = (r >= 2 && (c == 320 || c == 321)) ? 1020 : 0;
                        end
                        2: begin
                            y  = 8'($urandom_range(0, 255));
                            em = (r < 2 || c < 2) ? 0 : -1;
                        end
                        3: begin y = ((r + c) % 2 == 1) ? 8'hFF : 8'h00; em = 0; end
                        default: begin
                            y  = (r == 10 && c == 10) ? 8'hFF : 8'h00;
                            em = (r >= 10 && r <= 12 && c >= 10 && c <= 12 && !(r == 11 && c == 11)) ? 510 : 0;
                        end
                    endcase
                    // After a mid-frame reset the counters restart, so everything left in the frame is border.
                    if (dead) em = 0;
                    tick(1'b1, 1'b1, 1'b1, y, 1'b0, (em > th), (em >= 0), em);
                end
                if (gaps) tick(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 0);
            end
            // Horizontal blanking; clken toggles here to confirm href gates acceptance.
            for (int g = 0; g < 6; g++) tick(1'b1, 1'b0, g[0], 8'h33, 1'b0, 1'b0, 1'b1, 0);
        end
        repeat (4) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        pre_frame_vsync = 1'b0;
        pre_frame_href  = 1'b0;
        pre_frame_clken = 1'b0;
        pre_img_y       = 8'h00;
        threshold       = 11'd0;
        for (int i = 0; i < 4; i++) begin
            h_sync[i] = 3'b000;
            h_bit[i]  = 1'b0;
            h_chk[i]  = 1'b1;
            h_mag[i]  = 0;
        end

        // Reset state, with inputs held high to show they do not leak through.
        pre_frame_vsync = 1'b1;
        pre_frame_href  = 1'b1;
        pre_frame_clken = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit} === 4'b0000) else begin
            failures++;
            $error("FAIL reset_outputs got=%b want=0000", {post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit});
        end
`ifdef SOBEL_MAG_OUT_EN
        checks++;
        assert (post_mag === 11'd0) else begin
            failures++;
            $error("FAIL reset_mag got=%0d want=0", post_mag);
        end
`endif
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0);

        send_frame(0, 3, 0, 1'b0, -1, -1);     // flat frame, threshold 0: strict compare keeps all flags 0
        send_frame(1, 4, 500, 1'b0, -1, -1);   // step, threshold 500: flags at cols 320/321 from row 2
        send_frame(1, 3, 1020, 1'b0, -1, -1);  // step, threshold 1020: magnitude equals threshold, no flags
        send_frame(2, 3, 0, 1'b0, -1, -1);     // random: border zeros and sync alignment
        send_frame(1, 3, 500, 1'b1, -1, -1);   // step with clken 1,0,1,0 inside href
        send_frame(1, 4, 500, 1'b0, 3, 322);   // reset while the col 320/321 flags are in flight
        send_frame(1, 3, 500, 1'b0, -1, -1);   // first frame after reset behaves normally
        send_frame(3, 3, 0, 1'b0, -1, -1);     // checkerboard: zero magnitude
        send_frame(4, 13, 509, 1'b0, -1, -1);  // single dot: 510 > 509 around the dot
        send_frame(4, 13, 510, 1'b0, -1, -1);  // single dot: 510 is not > 510

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
